// File: rtl/spi_master_ctrl_if.sv
// Bus/pin bundle for the mode-0 SPI master sequencer.
// The master modport is the sequencer's view; the slave modport is the peripheral-bus/pin side.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  clk_div;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              ss_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  start, tx_data, clk_div, miso,
    output sclk, mosi, ss_n, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, clk_div, miso,
    input  sclk, mosi, ss_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master sequencer, MSB first, one slave select.
// One frame per accepted start; every timed phase lasts clk_div+1 clock cycles.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_ctrl_if.master   bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    TRAIL  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  div_q_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic              miso_q_r;
  logic              sclk_r;
  logic              mosi_r;
  logic              ss_n_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              h_end_s;

  assign h_end_s     = (div_cnt_r == div_q_r);
  assign bus.sclk    = sclk_r;
  assign bus.mosi    = mosi_r;
  assign bus.ss_n    = ss_n_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rx_data = rx_data_r;

  // Frame sequencer: state, divider, bit counter, shift register and all pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      div_q_r   <= {DIV_W{1'b0}};
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      shreg_r   <= {DATA_W{1'b0}};
      miso_q_r  <= 1'b0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      ss_n_r    <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rx_data_r <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r   <= LEAD;
            shreg_r   <= bus.tx_data;
            div_q_r   <= bus.clk_div;
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            ss_n_r    <= 1'b0;
            sclk_r    <= 1'b0;
            mosi_r    <= bus.tx_data[DATA_W-1];
            busy_r    <= 1'b1;
          end else begin
            ss_n_r <= 1'b1;
            sclk_r <= 1'b0;
            mosi_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        LEAD: begin
          if (h_end_s) begin
            state_r   <= SCK_HI;
            div_cnt_r <= {DIV_W{1'b0}};
            sclk_r    <= 1'b1;
            miso_q_r  <= bus.miso;
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        SCK_HI: begin
          if (h_end_s) begin
            state_r   <= SCK_LO;
            div_cnt_r <= {DIV_W{1'b0}};
            sclk_r    <= 1'b0;
            shreg_r   <= {shreg_r[DATA_W-2:0], miso_q_r};
            // After the last bit the shift register holds received data; keep it off the wire.
            if (bit_cnt_r == CNT_W'(DATA_W)) begin
              mosi_r <= 1'b0;
            end else begin
              mosi_r <= shreg_r[DATA_W-2];
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        SCK_LO: begin
          if (h_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (bit_cnt_r == CNT_W'(DATA_W)) begin
              state_r <= TRAIL;
            end else begin
              state_r   <= SCK_HI;
              sclk_r    <= 1'b1;
              miso_q_r  <= bus.miso;
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (h_end_s) begin
            state_r   <= DONE;
            div_cnt_r <= {DIV_W{1'b0}};
            ss_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
            done_r    <= 1'b1;
            rx_data_r <= shreg_r;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= {DIV_W{1'b0}};
          bit_cnt_r <= {CNT_W{1'b0}};
          sclk_r    <= 1'b0;
          mosi_r    <= 1'b0;
          ss_n_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed scenarios plus randomized frames
// checked against a frame-level model (latency, pulse widths, bit order, received word).
module tb_spi_master_ctrl;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  logic        loop_mode  = 1'b1;
  logic [7:0]  slave_word = 8'h00;
  int          rise_cnt   = 0;

  spi_master_ctrl_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  spi_master_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Slave model: either loops mosi back, or shifts out slave_word MSB first per sclk rise.
  always @(negedge bus.ss_n) rise_cnt <= 0;
  always @(posedge bus.sclk) rise_cnt <= rise_cnt + 1;
  assign bus.miso = loop_mode ? bus.mosi :
                    ((rise_cnt < DATA_W) ? slave_word[DATA_W-1-rise_cnt] : 1'b0);

  // inj_kind: 0 none, 1 extra start with 0x3C at sample inj_n, 2 clk_div->7 at sample inj_n
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] div, input logic [7:0] sw,
                           input logic loop, input int inj_n, input int inj_kind, input string tag);
    int h, lat, n, rises, run, done_at, done_cnt, bad_ss, bad_busy, bad_run, mosi_ones;
    logic prev;
    logic [7:0] mosi_word, exp_rx, rx_at_done;
    h = int'(div) + 1;
    lat = (2 * DATA_W + 2) * h;
    exp_rx = loop ? tx : sw;
    loop_mode = loop;
    slave_word = sw;
    rises = 0; run = 0; done_at = -1; done_cnt = 0;
    bad_ss = 0; bad_busy = 0; bad_run = 0; mosi_ones = 0;
    prev = 1'b0; mosi_word = 8'h00; rx_at_done = 8'h00;
    bus.start = 1'b1; bus.tx_data = tx; bus.clk_div = div;
    @(posedge clk);
    n = 0;
    while (n <= lat + 8 && (done_at < 0 || n <= done_at + 1)) begin
      @(negedge clk);
      if (n == 0) bus.start = 1'b0;
      if (inj_kind == 1 && n == inj_n) begin bus.start = 1'b1; bus.tx_data = 8'h3C; end
      if (inj_kind == 1 && n == inj_n + 1) bus.start = 1'b0;
      if (inj_kind == 2 && n == inj_n) bus.clk_div = 8'd7;
      if (done_at < 0) begin
        if (bus.done === 1'b1) begin
          done_at = n; done_cnt++; rx_at_done = bus.rx_data;
          if (bus.ss_n !== 1'b1) bad_ss++;
          if (bus.busy !== 1'b1) bad_busy++;
        end else begin
          if (bus.ss_n !== 1'b0) bad_ss++;
          if (bus.busy !== 1'b1) bad_busy++;
          if (bus.mosi === 1'b1) mosi_ones++;
          if (bus.sclk !== prev) begin
            if (run != h) bad_run++;
            if (prev == 1'b0) begin
              rises++;
              mosi_word = {mosi_word[6:0], bus.mosi};
            end
            run = 0;
            prev = bus.sclk;
          end
          run++;
        end
      end else if (bus.done === 1'b1) begin
        done_cnt++;
      end
      n++;
    end
    checks++; if (done_at !== lat) $display("FAIL %s latency: got %0d want %0d", tag, done_at, lat); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt); else passes++;
    checks++; if (rx_at_done !== exp_rx) $display("FAIL %s rx_data: got %h want %h", tag, rx_at_done, exp_rx); else passes++;
    checks++; if (rises !== DATA_W) $display("FAIL %s sclk_rises: got %0d want %0d", tag, rises, DATA_W); else passes++;
    checks++; if (mosi_word !== tx) $display("FAIL %s mosi_bits: got %h want %h", tag, mosi_word, tx); else passes++;
    checks++; if (bad_run !== 0) $display("FAIL %s sclk_phase_len: got %0d bad phases want 0", tag, bad_run); else passes++;
    checks++; if (bad_ss !== 0) $display("FAIL %s ss_n_frame: got %0d bad cycles want 0", tag, bad_ss); else passes++;
    checks++; if (bad_busy !== 0) $display("FAIL %s busy_frame: got %0d bad cycles want 0", tag, bad_busy); else passes++;
    checks++;
    if ({bus.busy, bus.ss_n, bus.done, bus.sclk} !== 4'b0100)
      $display("FAIL %s idle_after: got busy/ss_n/done/sclk=%b want 0100", tag, {bus.busy, bus.ss_n, bus.done, bus.sclk});
    else passes++;
    checks++; if (bus.rx_data !== exp_rx) $display("FAIL %s rx_hold: got %h want %h", tag, bus.rx_data, exp_rx); else passes++;
    if (tx == 8'h00) begin
      checks++; if (mosi_ones !== 0) $display("FAIL %s mosi_zero: got %0d high cycles want 0", tag, mosi_ones); else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.tx_data = 8'h00; bus.clk_div = 8'h00;
    #1;
    checks++;
    if ({bus.sclk, bus.mosi, bus.ss_n, bus.busy, bus.done} !== 5'b00100)
      $display("FAIL reset_pins: got sclk/mosi/ss_n/busy/done=%b want 00100", {bus.sclk, bus.mosi, bus.ss_n, bus.busy, bus.done});
    else passes++;
    checks++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx: got %h want 00", bus.rx_data); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(8'hA5, 8'd0, 8'h00, 1'b1, -1, 0, "loop_a5");
    run_frame(8'h00, 8'd3, 8'hFF, 1'b0, -1, 0, "miso_ones");
  endtask

  task automatic test_start_ignored();
    run_frame(8'hA5, 8'd0, 8'h00, 1'b1, 4, 1, "start_busy");
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    loop_mode = 1'b1;
    bus.start = 1'b1; bus.tx_data = 8'hA5; bus.clk_div = 8'd0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    checks++; if (bus.ss_n !== 1'b0) $display("FAIL midrst_pre: got ss_n=%b want 0", bus.ss_n); else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ss_n, bus.sclk, bus.busy, bus.done, bus.mosi} !== 5'b10000)
      $display("FAIL midrst_async: got ss_n/sclk/busy/done/mosi=%b want 10000", {bus.ss_n, bus.sclk, bus.busy, bus.done, bus.mosi});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.ss_n !== 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) $display("FAIL midrst_quiet: got %0d active cycles want 0", done_seen); else passes++;
    checks++; if (bus.rx_data !== 8'h00) $display("FAIL midrst_rx: got %h want 00", bus.rx_data); else passes++;
    run_frame(8'h5A, 8'd0, 8'h00, 1'b1, -1, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int done_q[$];
    int ss_runs[$];
    int hi_run, bad_rx;
    loop_mode = 1'b1;
    hi_run = 0; bad_rx = 0;
    bus.start = 1'b1; bus.tx_data = 8'hC3; bus.clk_div = 8'd1;
    @(posedge clk);
    for (int n = 0; n < 118; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_q.push_back(n);
        if (bus.rx_data !== 8'hC3) bad_rx++;
      end
      if (bus.ss_n === 1'b1) hi_run++;
      else if (hi_run > 0) begin ss_runs.push_back(hi_run); hi_run = 0; end
      if (n == 112) bus.start = 1'b0;
    end
    checks++; if (done_q.size() !== 3) $display("FAIL b2b_frames: got %0d want 3", done_q.size()); else passes++;
    for (int i = 0; i < done_q.size() && i < 3; i++) begin
      checks++;
      if (done_q[i] !== 36 + 38 * i) $display("FAIL b2b_done_time%0d: got %0d want %0d", i, done_q[i], 36 + 38 * i);
      else passes++;
    end
    checks++; if (ss_runs.size() !== 2) $display("FAIL b2b_gaps: got %0d want 2", ss_runs.size()); else passes++;
    foreach (ss_runs[i]) begin
      checks++; if (ss_runs[i] !== 2) $display("FAIL b2b_gap_len%0d: got %0d want 2", i, ss_runs[i]); else passes++;
    end
    checks++; if (bad_rx !== 0) $display("FAIL b2b_rx: got %0d bad words want 0", bad_rx); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b want 0", bus.busy); else passes++;
  endtask

  task automatic test_div_change();
    run_frame(8'h96, 8'd1, 8'h3B, 1'b0, 4, 2, "div_latched");
    run_frame(8'h69, 8'd7, 8'hE4, 1'b0, -1, 0, "div_next");
  endtask

  task automatic test_random();
    logic [7:0] tx, sw, dv;
    logic lp;
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom);
      sw = 8'($urandom);
      dv = 8'($urandom_range(0, 3));
      lp = 1'($urandom);
      run_frame(tx, dv, sw, lp, -1, 0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    test_div_change();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
